// File: rtl/logic_unit_arbiter_if.sv
// Request/response bus between the per-lane requesters and the shared logic unit arbiter.
// Optional rsp_err signal present when LOGIC_UNIT_ARB_ERR_EN is defined.
interface logic_unit_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ID_W    = 2
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ*3-1:0]      req_op;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_data;
    logic                      busy;
`ifdef LOGIC_UNIT_ARB_ERR_EN
    logic                      rsp_err;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, busy, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, busy, rsp_err
    );
`else
    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, busy
    );
`endif
endinterface

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one registered NAND-built bitwise logic unit among NUM_REQ requesters.
// Define LOGIC_UNIT_ARB_ERR_EN to flag the reserved opcode on rsp_err.
module logic_unit_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    logic_unit_arbiter_if.slave  bus
);

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_NAND = 3'd0;
    localparam logic [OP_W-1:0] OP_AND  = 3'd1;
    localparam logic [OP_W-1:0] OP_OR   = 3'd2;
    localparam logic [OP_W-1:0] OP_NOR  = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
    localparam logic [OP_W-1:0] OP_XNOR = 3'd5;
    localparam logic [OP_W-1:0] OP_NOTA = 3'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [ID_W-1:0]     r_rr_ptr;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [OP_W-1:0]     r_op;
    logic [ID_W-1:0]     r_id;
    logic                r_rsp_valid;
    logic [ID_W-1:0]     r_rsp_id;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_busy;

    logic                w_gnt_found;
    logic [ID_W-1:0]     w_gnt_idx;
    logic [ID_W-1:0]     w_cand;
    logic [NUM_REQ-1:0]  w_req_ready;
    logic [DATA_W-1:0]   w_sel_a;
    logic [DATA_W-1:0]   w_sel_b;
    logic [OP_W-1:0]     w_sel_op;

    logic [DATA_W-1:0]   w_n_ab;
    logic [DATA_W-1:0]   w_n_aa;
    logic [DATA_W-1:0]   w_n_bb;
    logic [DATA_W-1:0]   w_and;
    logic [DATA_W-1:0]   w_or;
    logic [DATA_W-1:0]   w_nor;
    logic [DATA_W-1:0]   w_xor;
    logic [DATA_W-1:0]   w_xnor;
    logic [DATA_W-1:0]   w_result;

    function automatic logic [DATA_W-1:0] f_nand(input logic [DATA_W-1:0] x,
                                                 input logic [DATA_W-1:0] y);
        return ~(x & y);
    endfunction

    // First pending requester strictly after the last one served, wrapping around.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_cand      = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_cand = ID_W'((32'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_gnt_found && bus.req_valid[w_cand]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = w_cand;
            end
        end
    end

    assign w_sel_a  = bus.req_a[32'(w_gnt_idx)*DATA_W +: DATA_W];
    assign w_sel_b  = bus.req_b[32'(w_gnt_idx)*DATA_W +: DATA_W];
    assign w_sel_op = bus.req_op[32'(w_gnt_idx)*OP_W +: OP_W];

    // Every function is composed from two-input NAND stages.
    assign w_n_ab = f_nand(r_a, r_b);
    assign w_n_aa = f_nand(r_a, r_a);
    assign w_n_bb = f_nand(r_b, r_b);
    assign w_and  = f_nand(w_n_ab, w_n_ab);
    assign w_or   = f_nand(w_n_aa, w_n_bb);
    assign w_nor  = f_nand(w_or, w_or);
    assign w_xor  = f_nand(f_nand(r_a, w_n_ab), f_nand(r_b, w_n_ab));
    assign w_xnor = f_nand(w_xor, w_xor);

    always_comb begin
        w_result = '0;
        case (r_op)
            OP_NAND: w_result = w_n_ab;
            OP_AND:  w_result = w_and;
            OP_OR:   w_result = w_or;
            OP_NOR:  w_result = w_nor;
            OP_XOR:  w_result = w_xor;
            OP_XNOR: w_result = w_xnor;
            OP_NOTA: w_result = w_n_aa;
            default: w_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and the combinational accept pulse, only ever raised in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = '0;
        case (r_state)
            IDLE: begin
                if (w_gnt_found) begin
                    w_req_ready[w_gnt_idx] = 1'b1;
                    w_state_nxt            = EXEC;
                end
            end
            EXEC: w_state_nxt = RESP;
            RESP: begin
                if (r_rsp_valid && bus.rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef LOGIC_UNIT_ARB_ERR_EN
    logic r_rsp_err;
    logic w_op_err;

    assign w_op_err = (r_op == 3'd7);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_err <= 1'b0;
        end else if (r_state == EXEC) begin
            r_rsp_err <= w_op_err;
        end
    end

    assign bus.rsp_err = r_rsp_err;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr    <= ID_W'(NUM_REQ - 1);
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_id        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != IDLE);
            case (r_state)
                IDLE: begin
                    if (w_gnt_found) begin
                        r_a  <= w_sel_a;
                        r_b  <= w_sel_b;
                        r_op <= w_sel_op;
                        r_id <= w_gnt_idx;
                    end
                end
                EXEC: begin
                    r_rsp_data  <= w_result;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (r_rsp_valid && bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rr_ptr    <= r_rsp_id;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.busy      = r_busy;

endmodule
